// File: rtl/keypad_guess_entry.sv
// Keypad front end: debounces decoder key codes into single key events and
// assembles them into a DIGITS-long BCD guess offered downstream over valid/ready.
module keypad_guess_entry #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   guess,
  output logic [DIGITS-1:0]     digit_mask,
  output logic                  guess_valid,
  input  logic                  guess_ready,
  output logic                  reject
);

  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    KEY_IDLE   = 4'hF;
  localparam logic [3:0]    KEY_SUBMIT = 4'hA;
  localparam logic [3:0]    KEY_BACK   = 4'hB;
  localparam logic [3:0]    KEY_CLEAR  = 4'hC;

  typedef enum logic {EDIT, OFFER} state_t;

  state_t                state, state_d;
  logic [3:0]            key_q, cand, last_acc;
  logic [CW-1:0]         stab_cnt;
  logic                  stable, key_evt;
  logic [4*DIGITS-1:0]   guess_d;
  logic [DIGITS-1:0]     mask_d;
  logic                  reject_d;
  logic                  full, empty;

  // A code that has already moved on in key_q is not treated as stable, so a
  // press must still be present on the processing edge to count.
  assign stable  = (stab_cnt == CNT_MAX) && (key_q == cand);
  assign key_evt = stable && (cand != KEY_IDLE) && (cand != last_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q    <= KEY_IDLE;
      cand     <= KEY_IDLE;
      stab_cnt <= '0;
      last_acc <= KEY_IDLE;
    end else begin
      key_q <= key_code;
      if (key_q != cand) begin
        cand     <= key_q;
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CW'(1);
      end
      if (stable)
        last_acc <= cand;
    end
  end

  // The mask is a thermometer from bit 0, so its end bits give full/empty.
  assign full        = digit_mask[DIGITS-1];
  assign empty       = !digit_mask[0];
  assign guess_valid = (state == OFFER);

  always_comb begin
    state_d  = state;
    guess_d  = guess;
    mask_d   = digit_mask;
    reject_d = 1'b0;
    case (state)
      EDIT: begin
        if (key_evt) begin
          if (cand <= 4'd9) begin
            if (full) begin
              reject_d = 1'b1;
            end else begin
              guess_d = {guess[4*DIGITS-5:0], cand};
              mask_d  = {digit_mask[DIGITS-2:0], 1'b1};
            end
          end else if (cand == KEY_SUBMIT) begin
            if (full)
              state_d = OFFER;
            else
              reject_d = 1'b1;
          end else if (cand == KEY_BACK) begin
            if (empty) begin
              reject_d = 1'b1;
            end else begin
              guess_d = {4'h0, guess[4*DIGITS-1:4]};
              mask_d  = {1'b0, digit_mask[DIGITS-1:1]};
            end
          end else if (cand == KEY_CLEAR) begin
            guess_d = '0;
            mask_d  = '0;
          end
        end
      end
      OFFER: begin
        if (key_evt)
          reject_d = 1'b1;
        if (guess_ready) begin
          guess_d = '0;
          mask_d  = '0;
          state_d = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EDIT;
      guess      <= '0;
      digit_mask <= '0;
      reject     <= 1'b0;
    end else begin
      state      <= state_d;
      guess      <= guess_d;
      digit_mask <= mask_d;
      reject     <= reject_d;
    end
  end

endmodule

// File: tb/tb_keypad_guess_entry.sv
// Scoreboard bench for keypad_guess_entry: every expected output change is queued
// with its cycle and a negedge monitor checks each change the DUT makes.
module tb_keypad_guess_entry;

  localparam int S  = 4;
  localparam int EV = S + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic [15:0] guess;
  logic [3:0]  digit_mask;
  logic        guess_valid;
  logic        guess_ready;
  logic        reject;

  typedef struct {
    int          cyc;
    logic [21:0] val;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          base = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;
  logic [21:0] prev;

  keypad_guess_entry #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .guess(guess),
    .digit_mask(digit_mask), .guess_valid(guess_valid),
    .guess_ready(guess_ready), .reject(reject)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: any change of the observable outputs consumes one expectation.
  always @(negedge clk) begin
    logic [21:0] snap;
    exp_t        e;
    snap = {guess, digit_mask, guess_valid, reject};
    if (mon_en && (snap !== prev)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_change: got %h at cycle %0d, required no change from %h", snap, cyc, prev);
      end else begin
        e = sb.pop_front();
        checkOutput("change_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("outputs", {10'h0, snap}, {10'h0, e.val});
      end
      prev = snap;
    end
  end

  task automatic expectChange(input int rel, input logic [15:0] g, input logic [3:0] m,
                              input logic v, input logic r);
    exp_t e;
    e.cyc = base + rel;
    e.val = {g, m, v, r};
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    key_code = k;
    base     = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind 0: no visible change, 1: outputs move to g/m/v, 2: reject pulse with g/m/v held
  task automatic press(input logic [3:0] k, input int n, input int kind,
                       input logic [15:0] g, input logic [3:0] m, input logic v);
    applyStimulus(k);
    if (kind == 1) begin
      expectChange(EV, g, m, v, 1'b0);
    end else if (kind == 2) begin
      expectChange(EV, g, m, v, 1'b1);
      expectChange(EV + 1, g, m, v, 1'b0);
    end
    hold(n);
  endtask

  initial begin
    rst_n       = 1'b0;
    key_code    = 4'hF;
    guess_ready = 1'b0;
    hold(3);
    checkOutput("reset_guess", 32'(guess), 32'h0);
    checkOutput("reset_mask", 32'(digit_mask), 32'h0);
    checkOutput("reset_valid", 32'(guess_valid), 32'h0);
    checkOutput("reset_reject", 32'(reject), 32'h0);
    rst_n  = 1'b1;
    prev   = {guess, digit_mask, guess_valid, reject};
    mon_en = 1'b1;
    hold(10);

    // Basic entry with an intervening idle, then submit and a long offer
    press(4'h1, 10, 1, 16'h0001, 4'h1, 1'b0);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);
    press(4'h2, 10, 1, 16'h0012, 4'h3, 1'b0);
    press(4'h3, 10, 1, 16'h0123, 4'h7, 1'b0);
    press(4'h4, 10, 1, 16'h1234, 4'hF, 1'b0);
    press(4'hA, EV + 20, 1, 16'h1234, 4'hF, 1'b1);
    base = cyc;
    expectChange(1, 16'h0, 4'h0, 1'b0, 1'b0);
    guess_ready = 1'b1;
    hold(1);
    guess_ready = 1'b0;
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);

    // Too-short press is filtered; a 5-cycle press lands
    press(4'h7, 3, 0, 16'h0, 4'h0, 1'b0);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);
    press(4'h7, 5, 1, 16'h0007, 4'h1, 1'b0);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);

    // Backspace and empty-buffer backspace rejects
    press(4'hC, 10, 1, 16'h0, 4'h0, 1'b0);
    press(4'h5, 10, 1, 16'h0005, 4'h1, 1'b0);
    press(4'h6, 10, 1, 16'h0056, 4'h3, 1'b0);
    press(4'hB, 10, 1, 16'h0005, 4'h1, 1'b0);
    press(4'hC, 10, 1, 16'h0, 4'h0, 1'b0);
    press(4'hB, 10, 2, 16'h0, 4'h0, 1'b0);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);
    press(4'hB, 10, 2, 16'h0, 4'h0, 1'b0);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);

    // Overflow digit and short submit are refused; ignored key D does nothing
    press(4'h1, 10, 1, 16'h0001, 4'h1, 1'b0);
    press(4'h2, 10, 1, 16'h0012, 4'h3, 1'b0);
    press(4'h3, 10, 1, 16'h0123, 4'h7, 1'b0);
    press(4'h4, 10, 1, 16'h1234, 4'hF, 1'b0);
    press(4'h5, 10, 2, 16'h1234, 4'hF, 1'b0);
    press(4'hD, 10, 0, 16'h0, 4'h0, 1'b0);
    press(4'hC, 10, 1, 16'h0, 4'h0, 1'b0);
    press(4'h1, 10, 1, 16'h0001, 4'h1, 1'b0);
    press(4'h2, 10, 1, 16'h0012, 4'h3, 1'b0);
    press(4'h3, 10, 1, 16'h0123, 4'h7, 1'b0);
    press(4'hA, 10, 2, 16'h0123, 4'h7, 1'b0);

    // Offer: clear is refused, then handshake collides with a key event
    press(4'h4, 10, 1, 16'h1234, 4'hF, 1'b0);
    press(4'hA, 10, 1, 16'h1234, 4'hF, 1'b1);
    press(4'hC, 10, 2, 16'h1234, 4'hF, 1'b1);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);
    applyStimulus(4'h9);
    expectChange(EV, 16'h0, 4'h0, 1'b0, 1'b1);
    expectChange(EV + 1, 16'h0, 4'h0, 1'b0, 1'b0);
    hold(EV - 1);
    guess_ready = 1'b1;
    hold(1);
    guess_ready = 1'b0;
    hold(4);
    press(4'hF, 10, 0, 16'h0, 4'h0, 1'b0);

    // Reset during an offer, with key 8 already held at release
    press(4'h1, 10, 1, 16'h0001, 4'h1, 1'b0);
    press(4'h2, 10, 1, 16'h0012, 4'h3, 1'b0);
    press(4'h3, 10, 1, 16'h0123, 4'h7, 1'b0);
    press(4'h4, 10, 1, 16'h1234, 4'hF, 1'b0);
    press(4'hA, 10, 1, 16'h1234, 4'hF, 1'b1);
    applyStimulus(4'h8);
    rst_n = 1'b0;
    expectChange(1, 16'h0, 4'h0, 1'b0, 1'b0);
    hold(3);
    rst_n = 1'b1;
    base  = cyc;
    expectChange(EV, 16'h0008, 4'h1, 1'b0, 1'b0);
    hold(20);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL missing_change: got no change by cycle %0d, required %h at cycle %0d", cyc, e.val, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_guess_entry.md
# keypad_guess_entry

Converts the 4-bit hex key code from the keypad column-scan decoder into a debounced stream of key events. Assembles those events into a multi-digit guess buffer with backspace, clear and submit keys. Presents each completed guess to the downstream compare stage over a valid/ready handshake. Exports the buffer and an occupancy mask to the seven-segment driver.

## Interface
- DIGITS, 4: guess length in decimal digits (2..8)
- STABLE_CYCLES, 100000: consecutive cycles a key code must hold before it is accepted (1 ms at 100 MHz); minimum 2
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- key_code  in  4  decoder output; 4'hF = idle/no key
- guess  out  4*DIGITS  BCD buffer; nibble 0 = most recently entered digit
- digit_mask  out  DIGITS  bit i set when nibble i holds an entered digit
- guess_valid  out  1  completed guess offered downstream
- guess_ready  in  1  downstream accepts guess when high with guess_valid
- reject  out  1  one-cycle pulse when a key event is refused

## Operation
- Input stage: key_code registered once into key_q; no other synchronisation.
- Stability filter: cand register plus counter stab_cnt, width clog2(STABLE_CYCLES).
  - key_q != cand: cand <= key_q, stab_cnt <= 0.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES-1.
  - cand is stable while stab_cnt == STABLE_CYCLES-1.
- Event generation: last_acc register, reset to 4'hF.
  - Stable cand == 4'hF: last_acc <= 4'hF, no event.
  - Stable cand != 4'hF and != last_acc: one key event with code cand; last_acc <= cand.
  - Repeating the same key needs an intervening stable 4'hF, because the decoder holds its last code.
- Key map:
  - 0–9: digit.
  - A: submit.
  - B: backspace.
  - C: clear.
  - D, E: ignored; no reject.
- Entry FSM, state EDIT (reset state):
  - Digit with count < DIGITS: guess <= {guess[4*DIGITS-5:0], digit}; mask <= {mask[DIGITS-2:0],1'b1}.
  - Digit with count == DIGITS: reject.
  - Backspace with count > 0: guess <= {4'h0, guess[4*DIGITS-1:4]}; mask <= {1'b0, mask[DIGITS-1:1]}.
  - Backspace with count == 0: reject.
  - Clear: guess <= 0, mask <= 0, from any count; never rejects.
  - Submit with count == DIGITS: go to OFFER.
  - Submit with count < DIGITS: reject.
- Entry FSM, state OFFER:
  - guess_valid = 1; guess and mask held constant.
  - guess_valid && guess_ready: guess <= 0, mask <= 0, back to EDIT.
  - Every key event in OFFER pulses reject and is otherwise dropped, including clear.
- count is popcount of digit_mask. Occupied bits are always contiguous from bit 0, so a DIGITS-bit thermometer suffices.

## Timing
- Reset values:
  - guess = 0, digit_mask = 0, guess_valid = 0, reject = 0.
  - FSM = EDIT, cand = 4'hF, stab_cnt = 0, last_acc = 4'hF, key_q = 4'hF.
- Latency: key_code changes before edge t and is held. The event is processed at edge t+STABLE_CYCLES+1, and guess, digit_mask and reject reflect it after that edge.
- A code held for fewer than STABLE_CYCLES+1 cycles produces no event. Glitches restart the count.
- At most one event per cycle. Events after the first need a new stable value.
- guess_valid rises the cycle after the accepted submit edge. It stays high, with guess stable, until sampled with guess_ready; it never drops without a handshake.
- guess_ready while guess_valid = 0 is ignored.
- A handshake and a key event in the same cycle: the handshake wins, the event is rejected and the buffer clears.
- reject is exactly one cycle wide per refused event.
- rst_n low at any edge, including mid-OFFER or mid-filter, restores all reset values at that edge. A pending offer is discarded.

## Test plan
- STABLE_CYCLES=4, DIGITS=4. Keys 1,F,2,3,4, each held 10 cycles, then A → guess=16'h1234, digit_mask=4'hF. guess_valid rises 6 cycles after A is applied, holds for 20 cycles with guess_ready=0, then clears guess to 0 one cycle after guess_ready=1.
- Key 7 held 3 cycles, then F → no event, guess=0. Key 7 held 5 cycles → guess=16'h0007 updated at edge t+5.
- Keys 5,6 then B → guess=16'h0005, digit_mask=4'h1. B,F,B on empty → reject pulses once per B press, and guess stays 0.
- Enter 1,2,3,4, then 5 → reject pulse, guess unchanged 16'h1234. Enter A with 3 digits → reject, guess_valid stays 0.
- In OFFER, press C → reject, guess held 16'h1234. Assert guess_ready on the same cycle as a key-9 event → handshake completes, reject=1, guess=0.
- Reset asserted during OFFER → all outputs 0 next cycle. Key 8 already stable at reset release → event after STABLE_CYCLES+1 cycles, guess=16'h0008.
